mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_dec.sv | 25 ++
 rtl/mc_ctrl.sv | 98 +++++++++
 tb/tb_mc_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and control-select encodings for the multicycle controller
package mc_pkg;
   typedef enum logic [3:0] {
      FETCH = 4'd0, DCD = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
      MW = 4'd5, EXE = 4'd6, AWB = 4'd7, BR = 4'd8, JMP = 4'd9
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;
   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;
   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;
   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;
   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_DM  = 2'b01;
   localparam logic [1:0] M2R_PC4 = 2'b10;
   typedef struct packed {
      logic addu, subu, slt, ori, lui, addi, lw, sw, beq, j, jal, jr;
   } cls_t;
endpackage

// File: rtl/mc_dec.sv
// mc_dec: maps op/funct to one-hot instruction class flags (all zero for unsupported encodings)
module mc_dec
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output cls_t       cls
);
   logic r;
   always_comb begin
      r        = op == OP_R;
      cls.addu = r && funct == F_ADDU;
      cls.subu = r && funct == F_SUBU;
      cls.slt  = r && funct == F_SLT;
      cls.jr   = r && funct == F_JR;
      cls.ori  = op == OP_ORI;
      cls.lui  = op == OP_LUI;
      cls.addi = op == OP_ADDI;
      cls.lw   = op == OP_LW;
      cls.sw   = op == OP_SW;
      cls.beq  = op == OP_BEQ;
      cls.j    = op == OP_J;
      cls.jal  = op == OP_JAL;
   end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle CPU control FSM; outputs are combinational from state, op/funct and zero
module mc_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcwr,
   output logic       irwr,
   output logic       gprwr,
   output logic       dmwr,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       write_30,
   output logic       ALUSrc,
   output logic [2:0] ALUOp,
   output logic [1:0] ExtOp,
   output logic [1:0] NPCOp,
   output logic [3:0] state
);
   cls_t   cls;
   state_t state_q, state_d;
   logic   rtype, alu_cls, jmp_cls;
   logic   pcwr_c, irwr_c, gprwr_c, dmwr_c, write_30_c;
   mc_dec u_dec (.op(op), .funct(funct), .cls(cls));
   assign rtype   = cls.addu | cls.subu | cls.slt;
   assign alu_cls = rtype | cls.ori | cls.lui | cls.addi;
   assign jmp_cls = cls.j | cls.jal | cls.jr;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= FETCH;
      else state_q <= state_d;
   always_comb begin
      state_d    = FETCH;
      pcwr_c     = 1'b0;
      irwr_c     = 1'b0;
      gprwr_c    = 1'b0;
      dmwr_c     = 1'b0;
      write_30_c = 1'b0;
      RegDst     = RD_RT;
      MemToReg   = M2R_ALU;
      ALUSrc     = 1'b0;
      ALUOp      = ALU_ADD;
      ExtOp      = EXT_ZERO;
      NPCOp      = NPC_PC4;
      case (state_q)
         FETCH: begin
            irwr_c  = 1'b1;
            pcwr_c  = 1'b1;
            state_d = DCD;
         end
         DCD: state_d = (cls.lw | cls.sw) ? MA : alu_cls ? EXE : cls.beq ? BR : jmp_cls ? JMP : FETCH;
         MA: begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_SIGN;
            state_d = cls.lw ? MR : cls.sw ? MW : FETCH;
         end
         MR: state_d = MWB;
         MWB: begin
            gprwr_c  = 1'b1;
            MemToReg = M2R_DM;
         end
         MW: dmwr_c = 1'b1;
         EXE: begin
            ALUSrc  = ~rtype;
            ALUOp   = cls.subu ? ALU_SUB : cls.slt ? ALU_SLT : cls.ori ? ALU_OR : cls.lui ? ALU_PASSB : ALU_ADD;
            ExtOp   = cls.lui ? EXT_LUI : cls.addi ? EXT_SIGN : EXT_ZERO;
            state_d = AWB;
         end
         AWB: begin
            gprwr_c    = 1'b1;
            RegDst     = rtype ? RD_RD : RD_RT;
            write_30_c = cls.addi;
         end
         BR: begin
            ALUOp  = ALU_SUB;
            NPCOp  = NPC_BR;
            pcwr_c = zero;
         end
         JMP: begin
            pcwr_c   = 1'b1;
            NPCOp    = cls.jr ? NPC_JR : NPC_J;
            gprwr_c  = cls.jal;
            RegDst   = cls.jal ? RD_RA : RD_RT;
            MemToReg = cls.jal ? M2R_PC4 : M2R_ALU;
         end
         default: ;
      endcase
   end
   // the reset state is FETCH, so its enables must be masked while rst is held
   assign pcwr     = pcwr_c & ~rst;
   assign irwr     = irwr_c & ~rst;
   assign gprwr    = gprwr_c & ~rst;
   assign dmwr     = dmwr_c & ~rst;
   assign write_30 = write_30_c & ~rst;
   assign state    = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and random instruction streams checked against a per-instruction step model
module tb_mc_ctrl;
   logic       clk, rst, zero;
   logic [5:0] op, funct;
   logic       pcwr, irwr, gprwr, dmwr, write_30, ALUSrc;
   logic [1:0] RegDst, MemToReg, ExtOp, NPCOp;
   logic [2:0] ALUOp;
   logic [3:0] state;
   logic [16:0] obs;
   int n_cmp = 0;
   int n_err = 0;
   typedef enum int {C_ADDU, C_SUBU, C_SLT, C_ORI, C_LUI, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_BAD} cls_e;
   localparam logic [5:0] OPS [12] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b001000,
                                       6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
   localparam logic [5:0] FNS [12] = '{6'b100001, 6'b100011, 6'b101010, 6'b0, 6'b0, 6'b0,
                                       6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b001000};
   mc_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .pcwr(pcwr), .irwr(irwr), .gprwr(gprwr), .dmwr(dmwr),
      .RegDst(RegDst), .MemToReg(MemToReg), .write_30(write_30), .ALUSrc(ALUSrc),
      .ALUOp(ALUOp), .ExtOp(ExtOp), .NPCOp(NPCOp), .state(state)
   );
   assign obs = {pcwr, irwr, gprwr, dmwr, RegDst, MemToReg, write_30, ALUSrc, ALUOp, ExtOp, NPCOp};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic cls_e classify(logic [5:0] o, logic [5:0] f);
      case (o)
         6'b000000: return f == 6'b100001 ? C_ADDU : f == 6'b100011 ? C_SUBU :
                           f == 6'b101010 ? C_SLT : f == 6'b001000 ? C_JR : C_BAD;
         6'b001101: return C_ORI;
         6'b001111: return C_LUI;
         6'b001000: return C_ADDI;
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000100: return C_BEQ;
         6'b000010: return C_J;
         6'b000011: return C_JAL;
         default:   return C_BAD;
      endcase
   endfunction
   // expected control word for instruction class c while in state st
   function automatic logic [16:0] exp_vec(cls_e c, int st, logic z);
      logic pc, ir, gw, dw, w30, src, r;
      logic [1:0] rd, m2r, ext, npc;
      logic [2:0] alu;
      {pc, ir, gw, dw, w30, src} = 6'b0;
      {rd, m2r, ext, npc} = 8'b0;
      alu = 3'd0;
      r = (c == C_ADDU) || (c == C_SUBU) || (c == C_SLT);
      case (st)
         0: begin ir = 1'b1; pc = 1'b1; end
         2: begin src = 1'b1; ext = 2'd1; end
         4: begin gw = 1'b1; m2r = 2'd1; end
         5: dw = 1'b1;
         6: begin
            src = ~r;
            alu = c == C_SUBU ? 3'd1 : c == C_SLT ? 3'd3 : c == C_ORI ? 3'd2 : c == C_LUI ? 3'd4 : 3'd0;
            ext = c == C_LUI ? 2'd2 : c == C_ADDI ? 2'd1 : 2'd0;
         end
         7: begin gw = 1'b1; rd = r ? 2'd1 : 2'd0; w30 = c == C_ADDI; end
         8: begin alu = 3'd1; npc = 2'd1; pc = z; end
         9: begin
            pc = 1'b1;
            npc = c == C_JR ? 2'd3 : 2'd2;
            if (c == C_JAL) begin gw = 1'b1; rd = 2'd2; m2r = 2'd2; end
         end
         default: ;
      endcase
      return {pc, ir, gw, dw, rd, m2r, w30, src, alu, ext, npc};
   endfunction
   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   // state path follows from the per-class latency: lw 5, sw/ALU 4, branch/jump 3, unknown 2
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int steps);
      cls_e c;
      int p[$];
      c = classify(o, f);
      p.push_back(0);
      p.push_back(1);
      case (c)
         C_LW:  begin p.push_back(2); p.push_back(3); p.push_back(4); end
         C_SW:  begin p.push_back(2); p.push_back(5); end
         C_BEQ: p.push_back(8);
         C_J, C_JAL, C_JR: p.push_back(9);
         C_BAD: ;
         default: begin p.push_back(6); p.push_back(7); end
      endcase
      for (int k = 0; k < p.size() && k < steps; k++) begin
         @(negedge clk);
         if (k == 0) begin op = o; funct = f; zero = z; end
         #1;
         check($sformatf("state op=%b f=%b k=%0d", o, f, k), 17'(state), 17'(p[k]));
         check($sformatf("outs op=%b f=%b k=%0d", o, f, k), obs, exp_vec(c, p[k], z));
      end
   endtask
   initial begin
      logic [5:0] o, f;
      int sel;
      rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset state", 17'(state), 17'd0);
      check("reset outs", obs, 17'd0);
      rst = 1'b0;
      run_instr(6'b000000, 6'b100001, 1'b0, 99);
      run_instr(6'b100011, 6'b010101, 1'b0, 99);
      run_instr(6'b101011, 6'b000000, 1'b1, 99);
      run_instr(6'b000100, 6'b000000, 1'b1, 99);
      run_instr(6'b000100, 6'b000000, 1'b0, 99);
      run_instr(6'b000011, 6'b000000, 1'b0, 99);
      run_instr(6'b000000, 6'b001000, 1'b1, 99);
      run_instr(6'b001000, 6'b111111, 1'b0, 99);
      run_instr(6'b111111, 6'b100001, 1'b1, 99);
      run_instr(6'b000000, 6'b111111, 1'b0, 99);
      // abort lw while it sits in MR
      run_instr(6'b100011, 6'b000000, 1'b0, 4);
      rst = 1'b1;
      #1;
      check("rst in MR state", 17'(state), 17'd0);
      check("rst in MR outs", obs, 17'd0);
      @(posedge clk);
      #1;
      check("rst held state", 17'(state), 17'd0);
      check("rst held outs", obs, 17'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr(6'b001111, 6'b000000, 1'b0, 99);
      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 15);
         f = 6'($urandom_range(0, 63));
         o = 6'($urandom_range(0, 63));
         if (sel < 12) begin
            o = OPS[sel];
            if (o == 6'b000000) f = FNS[sel];
         end
         run_instr(o, f, 1'($urandom_range(0, 1)), 99);
      end
      @(negedge clk);
      #1;
      check("final return to FETCH", 17'(state), 17'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
